grid_cursor_ctrl: RTL and testbench

Registered cursor controller for the whack-a-mole target grid. It replaces the single-step, down-only box mover with a parametrised ROWS×COLS cursor. The cursor has four direction buttons, input synchronisation, edge-triggered stepping, hold-to-auto-repeat, and a selectable wrap or saturate mode at the grid edges. It sits between the raw push-button inputs and the mole hit-check and display logic, which consume `pos`, `row` and `col`.

---
 rtl/grid_pkg.sv | 29 ++
 rtl/grid_cursor_ctrl_btn_sync.sv | 25 ++
 rtl/grid_cursor_ctrl.sv | 156 +++++++++++++++
 tb/tb_grid_cursor_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared types and default grid geometry for the mole-grid cursor, display and hit-check blocks.
`default_nettype none

package grid_pkg;

  localparam int DEF_ROWS = 3;
  localparam int DEF_COLS = 3;

  typedef enum logic [2:0] {
    NONE,
    UP,
    DOWN,
    LEFT,
    RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } rep_state_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/grid_cursor_ctrl_btn_sync.sv
// Two-flop synchroniser for one raw push-button level.
`default_nettype none

module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/grid_cursor_ctrl.sv
// ROWSxCOLS grid cursor: synchronised buttons, edge-triggered steps with hold-to-repeat,
// wrap or saturate at the edges, registered position outputs.
`default_nettype none

module grid_cursor_ctrl
  import grid_pkg::*;
#(
  parameter int ROWS         = DEF_ROWS,
  parameter int COLS         = DEF_COLS,
  parameter int WRAP         = 1,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          btn_up,
  input  logic                          btn_down,
  input  logic                          btn_left,
  input  logic                          btn_right,
  output logic [$clog2(ROWS*COLS)-1:0]  pos,
  output logic [$clog2(ROWS)-1:0]       row,
  output logic [$clog2(COLS)-1:0]       col,
  output logic                          moved
);

  localparam int PW   = $clog2(ROWS*COLS);
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);
  localparam int CNTW = $clog2(imax(REPEAT_DELAY, REPEAT_RATE));

  localparam logic [RW-1:0]   ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0]   COL_LAST  = CW'(COLS - 1);
  localparam logic [CNTW-1:0] CNT_DELAY = CNTW'(REPEAT_DELAY - 1);
  localparam logic [CNTW-1:0] CNT_RATE  = CNTW'(REPEAT_RATE - 1);

  logic s_up, s_down, s_left, s_right;

  btn_sync u_sync_up    (.clk(clk), .rst_n(rst_n), .d(btn_up),    .q(s_up));
  btn_sync u_sync_down  (.clk(clk), .rst_n(rst_n), .d(btn_down),  .q(s_down));
  btn_sync u_sync_left  (.clk(clk), .rst_n(rst_n), .d(btn_left),  .q(s_left));
  btn_sync u_sync_right (.clk(clk), .rst_n(rst_n), .d(btn_right), .q(s_right));

  dir_t            req, dir_q, dir_n, step_dir;
  rep_state_t      state, state_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic [RW-1:0]   row_n;
  logic [CW-1:0]   col_n;
  logic [PW-1:0]   pos_n;
  logic            moved_n;

  // Only a single pressed button is a request; chords cancel out.
  always_comb begin
    req = NONE;
    case ({s_up, s_down, s_left, s_right})
      4'b1000: req = UP;
      4'b0100: req = DOWN;
      4'b0010: req = LEFT;
      4'b0001: req = RIGHT;
      default: req = NONE;
    endcase
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dir_n    = dir_q;
    step_dir = NONE;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      dir_n   = NONE;
    end else begin
      case (state)
        IDLE: begin
          if (req != NONE) begin
            step_dir = req;
            dir_n    = req;
            cnt_n    = CNT_DELAY;
            state_n  = HOLD;
          end
        end
        HOLD, REPEAT: begin
          // A dropped or changed request always goes back through IDLE.
          if (req != dir_q) begin
            state_n = IDLE;
            cnt_n   = '0;
            dir_n   = NONE;
          end else if (cnt == '0) begin
            step_dir = dir_q;
            cnt_n    = CNT_RATE;
            state_n  = REPEAT;
          end else begin
            cnt_n = cnt - CNTW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          dir_n   = NONE;
        end
      endcase
    end
  end

  always_comb begin
    row_n = row;
    col_n = col;
    case (step_dir)
      UP: begin
        if (row != '0)    row_n = row - RW'(1);
        else if (WRAP != 0) row_n = ROW_LAST;
      end
      DOWN: begin
        if (row != ROW_LAST) row_n = row + RW'(1);
        else if (WRAP != 0)  row_n = '0;
      end
      LEFT: begin
        if (col != '0)    col_n = col - CW'(1);
        else if (WRAP != 0) col_n = COL_LAST;
      end
      RIGHT: begin
        if (col != COL_LAST) col_n = col + CW'(1);
        else if (WRAP != 0)  col_n = '0;
      end
      default: ;
    endcase
    moved_n = (row_n != row) || (col_n != col);
    pos_n   = PW'(row_n) * PW'(COLS) + PW'(col_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      dir_q <= NONE;
      row   <= '0;
      col   <= '0;
      pos   <= '0;
      moved <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dir_q <= dir_n;
      moved <= moved_n;
      if (moved_n) begin
        row <= row_n;
        col <= col_n;
        pos <= pos_n;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_grid_cursor_ctrl.sv
// Directed bench for grid_cursor_ctrl: a wrapping 3x3 instance plus a saturating one.
`default_nettype none

module tb_grid_cursor_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] btns = 4'b0000;   // {up, down, left, right}
  logic [3:0] sbtns = 4'b0000;

  logic [3:0] pos, s_pos;
  logic [1:0] row, col, s_row, s_col;
  logic       moved, s_moved;

  int checks = 0;
  int errors = 0;
  int mv = 0;
  int smv = 0;
  int base;

  always #5 clk = ~clk;

  grid_cursor_ctrl #(.ROWS(3), .COLS(3), .WRAP(1), .REPEAT_DELAY(8), .REPEAT_RATE(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .btn_up(btns[3]), .btn_down(btns[2]), .btn_left(btns[1]), .btn_right(btns[0]),
    .pos(pos), .row(row), .col(col), .moved(moved)
  );

  grid_cursor_ctrl #(.ROWS(3), .COLS(3), .WRAP(0), .REPEAT_DELAY(8), .REPEAT_RATE(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .btn_up(sbtns[3]), .btn_down(sbtns[2]), .btn_left(sbtns[1]), .btn_right(sbtns[0]),
    .pos(s_pos), .row(s_row), .col(s_col), .moved(s_moved)
  );

  always @(negedge clk) begin
    if (moved)   mv++;
    if (s_moved) smv++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic spulse(input logic [3:0] b, input int hold);
    sbtns = b;
    tick(hold);
    sbtns = 4'b0000;
    tick(4);
  endtask

  task automatic pulse(input logic [3:0] b, input int hold);
    btns = b;
    tick(hold);
    btns = 4'b0000;
    tick(4);
  endtask

  initial begin
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("idle_pos", pos, 0);
      chk("idle_rowcol", {row, col}, 0);
      chk("idle_moved", moved, 0);
    end

    // Saturating instance: walk to (2,2), then push past both edges.
    spulse(4'b0100, 3);
    spulse(4'b0100, 3);
    spulse(4'b0001, 3);
    spulse(4'b0001, 3);
    chk("sat_corner_pos", s_pos, 8);
    chk("sat_corner_moves", smv, 4);
    spulse(4'b0100, 14);
    spulse(4'b0001, 14);
    chk("sat_edge_pos", s_pos, 8);
    chk("sat_edge_rowcol", {s_row, s_col}, 4'b1010);
    chk("sat_edge_no_moved", smv, 4);

    // First-step latency: press after edge E0, step lands on E3.
    base = mv;
    btns = 4'b0001;
    tick(2);
    chk("lat_e2_col", col, 0);
    chk("lat_e2_moved", moved, 0);
    tick(1);
    chk("lat_e3_col", col, 1);
    chk("lat_e3_pos", pos, 1);
    chk("lat_e3_moved", moved, 1);
    tick(1);
    chk("lat_e4_moved", moved, 0);
    tick(1);
    btns = 4'b0000;
    tick(4);
    chk("lat_single_pulse", mv - base, 1);

    pulse(4'b0001, 3);
    chk("wrap_r_col2", col, 2);
    pulse(4'b0001, 3);
    chk("wrap_r_col0", col, 0);
    chk("wrap_r_pos0", pos, 0);
    pulse(4'b0001, 3);
    chk("wrap_r_col1", col, 1);
    chk("wrap_r_row0", row, 0);

    // Auto-repeat on down: t, t+8, t+12, t+16.
    base = mv;
    btns = 4'b0100;
    tick(3);
    chk("rep_t_row", row, 1);
    tick(7);
    chk("rep_t7_row", row, 1);
    chk("rep_t7_moves", mv - base, 1);
    tick(1);
    chk("rep_t8_row", row, 2);
    chk("rep_t8_moved", moved, 1);
    tick(3);
    chk("rep_t11_row", row, 2);
    tick(1);
    chk("rep_t12_row", row, 0);
    tick(4);
    chk("rep_t16_row", row, 1);
    btns = 4'b0000;
    tick(8);
    chk("rep_release_row", row, 1);
    chk("rep_release_pos", pos, 4);
    chk("rep_release_moves", mv - base, 4);

    // Opposing chord cancels; releasing one side is a fresh press.
    base = mv;
    btns = 4'b0011;
    tick(6);
    chk("chord_col", col, 1);
    chk("chord_moves", mv - base, 0);
    btns = 4'b0010;
    tick(2);
    chk("chord_rel_e2_col", col, 1);
    tick(1);
    chk("chord_rel_col", col, 0);
    chk("chord_rel_moved", moved, 1);
    btns = 4'b0000;
    tick(4);
    chk("chord_pos", pos, 3);

    // enable drop mid-repeat, then re-raise with up still held.
    btns = 4'b1000;
    tick(3);
    chk("en_first_row", row, 0);
    tick(8);
    chk("en_rep_row", row, 2);
    tick(1);
    enable = 1'b0;
    base = mv;
    tick(6);
    chk("en_frozen_row", row, 2);
    chk("en_frozen_moves", mv - base, 0);
    enable = 1'b1;
    tick(1);
    chk("en_rise_row", row, 1);
    chk("en_rise_moved", moved, 1);
    tick(7);
    chk("en_delay_row", row, 1);
    tick(1);
    chk("en_resume_row", row, 0);
    btns = 4'b0000;
    tick(4);
    chk("en_end_pos", pos, 0);

    // Asynchronous reset while a button is held.
    btns = 4'b0001;
    tick(5);
    chk("arst_pre_col", col, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pos", pos, 0);
    chk("arst_rowcol", {row, col}, 0);
    chk("arst_sat_pos", s_pos, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("arst_refill_col", col, 0);
    tick(1);
    chk("arst_fresh_col", col, 1);
    chk("arst_fresh_moved", moved, 1);
    btns = 4'b0000;
    tick(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
